cgra_banked_sram: RTL and testbench



---
 rtl/cgra_sram_pkg.sv | 20 ++
 rtl/cgra_sram_bank.sv | 35 +++
 rtl/cgra_banked_sram.sv | 171 +++++++++++++++++
 tb/tb_cgra_banked_sram.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_sram_pkg.sv
// Shared types and address-split helpers for the banked CGRA SRAM.
package cgra_sram_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        DRAIN     = 2'd1,
        RETENTIVE = 2'd2,
        WAKE      = 2'd3
    } ret_state_e;

    // Word-interleaved mapping: low address bits pick the bank, the rest pick the row.
    function automatic int unsigned bank_index(input int unsigned addr, input int unsigned num_banks);
        return addr % num_banks;
    endfunction

    function automatic int unsigned row_index(input int unsigned addr, input int unsigned num_banks);
        return addr / num_banks;
    endfunction

endpackage

// File: rtl/cgra_sram_bank.sv
// Single-port byte-enabled SRAM bank with a registered (1-cycle) read port.
module cgra_sram_bank #(
    parameter int unsigned Words      = 1024,
    parameter int unsigned DataWidth  = 32,
    localparam int unsigned RowW      = $clog2(Words),
    localparam int unsigned BeW       = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [RowW-1:0]      addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeW-1:0]       be_i,
    output logic [DataWidth-1:0] rdata_o
);
    import cgra_sram_pkg::*;

    logic [DataWidth-1:0] r_mem [Words];
    logic [DataWidth-1:0] w_mask;

    for (genvar g = 0; g < BeW; g++) begin : g_mask
        assign w_mask[g*8 +: 8] = {8{be_i[g]}};
    end

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                r_mem[addr_i] <= (r_mem[addr_i] & ~w_mask) | (wdata_i & w_mask);
            end else begin
                rdata_o <= r_mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/cgra_banked_sram.sv
// Multi-port word-interleaved banked SRAM: per-bank round-robin arbitration,
// per-port response routing and a retention FSM (drain / retain / wake).
module cgra_banked_sram #(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned WordsPerBank = 1024,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned WakeupCycles = 4,
    localparam int unsigned AddrWidth   = $clog2(NumBanks * WordsPerBank)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumPorts-1:0]                    req_i,
    output logic [NumPorts-1:0]                    gnt_o,
    input  logic [NumPorts-1:0]                    we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0]   be_i,
    output logic [NumPorts-1:0]                    rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]     rdata_o,
    input  logic                                   set_retentive_ni,
    output logic                                   retentive_o
);
    import cgra_sram_pkg::*;

    localparam int unsigned PortIdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned BankIdxW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned RowW     = $clog2(WordsPerBank);
    localparam int unsigned CntW     = (WakeupCycles > 1) ? $clog2(WakeupCycles) : 1;

    if ((NumBanks & (NumBanks - 1)) != 0) begin : g_err_banks
        $error("NumBanks must be a power of two");
    end
    if ((WordsPerBank & (WordsPerBank - 1)) != 0 || WordsPerBank < 2) begin : g_err_words
        $error("WordsPerBank must be a power of two >= 2");
    end
    if ((DataWidth % 8) != 0) begin : g_err_width
        $error("DataWidth must be a multiple of 8");
    end

    ret_state_e                                r_state;
    logic [CntW-1:0]                           r_wake_cnt;
    logic                                      w_grant_en;
    logic [NumPorts-1:0][BankIdxW-1:0]         w_bank_sel;
    logic [NumPorts-1:0][RowW-1:0]             w_row;
    logic [NumBanks-1:0][NumPorts-1:0]         w_bank_gnt;
    logic [NumBanks-1:0][DataWidth-1:0]        w_bk_rdata;

    // Grants are gated by reset so nothing is accepted while rst_ni is low.
    assign w_grant_en  = rst_ni && (r_state == ACTIVE);
    assign retentive_o = (r_state == RETENTIVE);

    for (genvar g = 0; g < NumBanks; g++) begin : g_bank
        logic [NumPorts-1:0] w_cand;
        logic [PortIdxW-1:0] r_ptr;
        logic [PortIdxW-1:0] w_idx;
        logic [PortIdxW-1:0] w_win;
        logic                w_act;

        for (genvar q = 0; q < NumPorts; q++) begin : g_cand
            assign w_cand[q] = req_i[q] && (w_bank_sel[q] == BankIdxW'(g));
        end

        always_comb begin
            w_act = 1'b0;
            w_win = '0;
            w_idx = '0;
            for (int unsigned k = 0; k < NumPorts; k++) begin
                w_idx = PortIdxW'((32'(r_ptr) + k) % NumPorts);
                if (!w_act && w_grant_en && w_cand[w_idx]) begin
                    w_act = 1'b1;
                    w_win = w_idx;
                end
            end
        end

        assign w_bank_gnt[g] = w_act ? (NumPorts'(1) << w_win) : '0;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ptr <= '0;
            end else if (w_act) begin
                r_ptr <= (w_win == PortIdxW'(NumPorts - 1)) ? '0 : w_win + 1'b1;
            end
        end

        cgra_sram_bank #(
            .Words     (WordsPerBank),
            .DataWidth (DataWidth)
        ) u_bank (
            .clk_i   (clk_i),
            .req_i   (w_act),
            .we_i    (we_i[w_win]),
            .addr_i  (w_row[w_win]),
            .wdata_i (wdata_i[w_win]),
            .be_i    (be_i[w_win]),
            .rdata_o (w_bk_rdata[g])
        );
    end

    for (genvar q = 0; q < NumPorts; q++) begin : g_port
        logic [NumBanks-1:0] w_hit;
        logic                r_valid;
        logic                r_rd;
        logic [BankIdxW-1:0] r_bank;
        logic [DataWidth-1:0] r_hold;

        assign w_bank_sel[q] = BankIdxW'(bank_index(32'(addr_i[q]), NumBanks));
        assign w_row[q]      = RowW'(row_index(32'(addr_i[q]), NumBanks));

        for (genvar g = 0; g < NumBanks; g++) begin : g_hit
            assign w_hit[g] = w_bank_gnt[g][q];
        end
        assign gnt_o[q] = |w_hit;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
                r_rd    <= 1'b0;
                r_bank  <= '0;
                r_hold  <= '0;
            end else begin
                r_valid <= gnt_o[q];
                if (gnt_o[q]) begin
                    r_bank <= w_bank_sel[q];
                    r_rd   <= !we_i[q];
                end
                if (r_valid && r_rd) begin
                    r_hold <= w_bk_rdata[r_bank];
                end
            end
        end

        // Read responses come straight from the bank register; otherwise the last read value is held.
        assign rvalid_o[q] = r_valid;
        assign rdata_o[q]  = (r_valid && r_rd) ? w_bk_rdata[r_bank] : r_hold;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ACTIVE;
            r_wake_cnt <= '0;
        end else begin
            case (r_state)
                ACTIVE: begin
                    if (!set_retentive_ni) r_state <= DRAIN;
                end
                // No grants issue in DRAIN, so responses in flight complete during this cycle.
                DRAIN: r_state <= RETENTIVE;
                RETENTIVE: begin
                    if (set_retentive_ni) begin
                        r_state    <= WAKE;
                        r_wake_cnt <= CntW'(WakeupCycles - 1);
                    end
                end
                WAKE: begin
                    if (!set_retentive_ni) begin
                        r_state    <= RETENTIVE;
                        r_wake_cnt <= '0;
                    end else if (r_wake_cnt == '0) begin
                        r_state <= ACTIVE;
                    end else begin
                        r_wake_cnt <= r_wake_cnt - 1'b1;
                    end
                end
                default: r_state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_banked_sram.sv
// Directed scoreboard bench for cgra_banked_sram: grants, responses, byte enables,
// arbitration order, retention timing and reset behaviour.
module tb_cgra_banked_sram;

    localparam int unsigned NP = 2;
    localparam int unsigned NB = 4;
    localparam int unsigned WPB = 1024;
    localparam int unsigned DW = 32;
    localparam int unsigned WK = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;

    typedef logic [PW-1:0] pidx_t;
    typedef struct packed {
        pidx_t         port;
        logic          rd;
        logic [DW-1:0] data;
    } rsp_t;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NP-1:0]             req_i, gnt_o, we_i, rvalid_o;
    logic [NP-1:0][AW-1:0]     addr_i;
    logic [NP-1:0][DW-1:0]     wdata_i, rdata_o;
    logic [NP-1:0][DW/8-1:0]   be_i;
    logic                      set_retentive_ni, retentive_o;

    rsp_t                      q[$];
    logic [DW-1:0]             model [int unsigned];
    logic [DW-1:0]             last_rd [NP];
    int                        n_assert = 0;
    int                        n_fail = 0;

    always #5 clk_i = ~clk_i;

    cgra_banked_sram #(
        .NumPorts     (NP),
        .NumBanks     (NB),
        .WordsPerBank (WPB),
        .DataWidth    (DW),
        .WakeupCycles (WK)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .set_retentive_ni (set_retentive_ni),
        .retentive_o      (retentive_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [3:0] be);
        logic [DW-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (nd & m);
    endfunction

    task automatic idle();
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    task automatic drive(input int unsigned i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        pidx_t p;
        p = pidx_t'(i);
        req_i[p] = 1'b1; we_i[p] = we; addr_i[p] = a; wdata_i[p] = d; be_i[p] = be;
    endtask

    // Check this cycle's grants, score the expected responses, then check them after the edge.
    task automatic step(input logic [NP-1:0] exp_gnt, input logic exp_ret);
        logic [NP-1:0] exp_rv;
        logic [DW-1:0] exp_d [NP];
        int unsigned   a;
        rsp_t          e;
        pidx_t         p;
        #1;
        chk("gnt", 32'(gnt_o), 32'(exp_gnt));
        chk("retentive", 32'(retentive_o), 32'(exp_ret));
        for (int unsigned i = 0; i < NP; i++) begin
            p = pidx_t'(i);
            if (exp_gnt[p]) begin
                a = 32'(addr_i[p]);
                if (we_i[p]) begin
                    model[a] = merge(model.exists(a) ? model[a] : '0, wdata_i[p], be_i[p]);
                    q.push_back('{port: p, rd: 1'b0, data: '0});
                end else begin
                    q.push_back('{port: p, rd: 1'b1, data: model[a]});
                end
            end
        end
        @(posedge clk_i);
        #1;
        exp_rv = '0;
        for (int unsigned i = 0; i < NP; i++) exp_d[pidx_t'(i)] = last_rd[pidx_t'(i)];
        while (q.size() > 0) begin
            e = q.pop_front();
            exp_rv[e.port] = 1'b1;
            if (e.rd) exp_d[e.port] = e.data;
        end
        for (int unsigned i = 0; i < NP; i++) begin
            p = pidx_t'(i);
            chk($sformatf("rvalid%0d", i), 32'(rvalid_o[p]), 32'(exp_rv[p]));
            chk($sformatf("rdata%0d", i), rdata_o[p], exp_d[p]);
            last_rd[p] = exp_d[p];
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        set_retentive_ni = 1'b1;
        idle();
        for (int unsigned i = 0; i < NP; i++) last_rd[pidx_t'(i)] = '0;
        req_i = '1;
        @(posedge clk_i);
        #2;
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        chk("reset_rvalid", 32'(rvalid_o), 32'd0);
        chk("reset_rdata0", rdata_o[0], 32'd0);
        chk("reset_rdata1", rdata_o[1], 32'd0);
        chk("reset_retentive", 32'(retentive_o), 32'd0);
        @(posedge clk_i);
        #1;
        idle();
        rst_ni = 1'b1;
        step(2'b00, 1'b0);

        // Single port write then read
        drive(0, 1'b1, 12'd5, 32'hDEADBEEF, 4'hF); step(2'b01, 1'b0);
        idle(); drive(0, 1'b0, 12'd5, '0, 4'h0);   step(2'b01, 1'b0);
        idle();                                     step(2'b00, 1'b0);

        // Byte enables, including an all-zero byte mask
        drive(0, 1'b1, 12'd9, 32'hFFFFFFFF, 4'hF); step(2'b01, 1'b0);
        drive(0, 1'b1, 12'd9, 32'h00000000, 4'h5); step(2'b01, 1'b0);
        drive(0, 1'b1, 12'd9, 32'h12345678, 4'h0); step(2'b01, 1'b0);
        drive(0, 1'b0, 12'd9, '0, 4'h0);            step(2'b01, 1'b0);
        idle();
        chk("byte_enable_value", rdata_o[0], 32'hFF00FF00);

        // Preload bank 2 from port 1 so its pointer returns to 0, then contend
        drive(1, 1'b1, 12'd2, 32'hA2A2A2A2, 4'hF); step(2'b10, 1'b0);
        drive(1, 1'b1, 12'd6, 32'h66666666, 4'hF); step(2'b10, 1'b0);
        idle();
        drive(0, 1'b0, 12'd2, '0, 4'h0);
        drive(1, 1'b0, 12'd6, '0, 4'h0);
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        idle();

        // Parallel access to different banks
        drive(0, 1'b1, 12'd0, 32'h00001111, 4'hF);
        drive(1, 1'b1, 12'd1, 32'h22220000, 4'hF);
        step(2'b11, 1'b0);
        drive(0, 1'b0, 12'd0, '0, 4'h0);
        drive(1, 1'b0, 12'd1, '0, 4'h0);
        step(2'b11, 1'b0);
        idle();

        // Retention entry with a read in flight, held request, then wake-up
        drive(0, 1'b1, 12'd7, 32'h00001234, 4'hF); step(2'b01, 1'b0);
        drive(0, 1'b0, 12'd7, '0, 4'h0);
        set_retentive_ni = 1'b0;
        step(2'b01, 1'b0);
        step(2'b00, 1'b0);
        for (int unsigned i = 0; i < 10; i++) step(2'b00, 1'b1);
        set_retentive_ni = 1'b1;
        step(2'b00, 1'b1);
        for (int unsigned i = 0; i < WK; i++) step(2'b00, 1'b0);
        step(2'b01, 1'b0);
        idle();
        chk("retention_data", rdata_o[0], 32'h00001234);
        step(2'b00, 1'b0);

        // Reset asserted while a read response is pending
        drive(0, 1'b0, 12'd5, '0, 4'h0);
        #1;
        chk("pre_reset_gnt", 32'(gnt_o), 32'd1);
        #3;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midreset_rvalid", 32'(rvalid_o), 32'd0);
        chk("midreset_gnt", 32'(gnt_o), 32'd0);
        chk("midreset_rdata0", rdata_o[0], 32'd0);
        chk("midreset_rdata1", rdata_o[1], 32'd0);
        chk("midreset_retentive", 32'(retentive_o), 32'd0);
        for (int unsigned i = 0; i < NP; i++) last_rd[pidx_t'(i)] = '0;
        @(posedge clk_i);
        #1;
        idle();
        rst_ni = 1'b1;
        step(2'b00, 1'b0);

        // Bank 1 pointer must be back at port 0; memory survives reset
        drive(0, 1'b0, 12'd5, '0, 4'h0);
        drive(1, 1'b0, 12'd9, '0, 4'h0);
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        idle();
        step(2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
